// File: rtl/stopwatch_rtl.sv
// Count-up stopwatch: a prescaler makes one-second ticks, seconds accumulate as
// two BCD digits, and a lap hold can freeze the two active-low 7-segment digits.
module stopwatch_rtl #(
   parameter int CLK_SET = 5_000_000,
   parameter int LIMIT   = 99
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic       lap,
   output logic [6:0] cur_sec,
   output logic       full,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [1:0] state
);

   localparam int            PW       = $clog2(CLK_SET);
   localparam logic [PW-1:0] P_LAST   = PW'(CLK_SET - 1);
   localparam logic [3:0]    LIM_ONES = 4'(LIMIT % 10);
   localparam logic [3:0]    LIM_TENS = 4'(LIMIT / 10);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [PW-1:0]   r_presc;
   logic [3:0]      r_ones;
   logic [3:0]      r_tens;
   logic [3:0]      r_latch_ones;
   logic [3:0]      r_latch_tens;
   logic            r_hold;
   logic            r_lap_q;
   logic [6:0]      r_hex0;
   logic [6:0]      r_hex1;

   logic            w_tick;
   logic [3:0]      w_ones_nx;
   logic [3:0]      w_tens_nx;
   logic            w_hit_limit;
   logic            w_lap_ok;
   logic [3:0]      w_disp_ones;
   logic [3:0]      w_disp_tens;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // The prescaler advances on every RUN cycle regardless of en, so the cycle
   // that leaves RUN still counts toward the current second.
   assign w_tick = (r_state == S_RUN) && (r_presc == P_LAST);

   always_comb begin
      w_ones_nx = r_ones + 4'd1;
      w_tens_nx = r_tens;
      if (r_ones == 4'd9) begin
         w_ones_nx = 4'd0;
         w_tens_nx = r_tens + 4'd1;
      end
   end

   assign w_hit_limit = w_tick && (w_ones_nx == LIM_ONES) && (w_tens_nx == LIM_TENS);
   assign w_lap_ok    = lap && !r_lap_q && ((r_state == S_RUN) || (r_state == S_PAUSE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      if (clr) begin
         w_state_nx = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (en) w_state_nx = S_RUN;
            S_RUN: begin
               if (w_hit_limit) begin
                  w_state_nx = S_DONE;
               end else if (!en) begin
                  w_state_nx = S_PAUSE;
               end
            end
            S_PAUSE: if (en) w_state_nx = S_RUN;
            S_DONE:  w_state_nx = S_DONE;
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_ones  <= 4'd0;
         r_tens  <= 4'd0;
      end else if (clr) begin
         r_presc <= '0;
         r_ones  <= 4'd0;
         r_tens  <= 4'd0;
      end else begin
         if (r_state == S_RUN) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
         end
         if (w_tick) begin
            r_ones <= w_ones_nx;
            r_tens <= w_tens_nx;
         end
      end
   end

   // Reaching the limit drops the hold so the final count is what gets shown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lap_q      <= 1'b0;
         r_hold       <= 1'b0;
         r_latch_ones <= 4'd0;
         r_latch_tens <= 4'd0;
      end else if (clr) begin
         r_lap_q <= 1'b0;
         r_hold  <= 1'b0;
      end else begin
         r_lap_q <= lap;
         if (w_hit_limit) begin
            r_hold <= 1'b0;
         end else if (w_lap_ok) begin
            r_hold <= !r_hold;
            if (!r_hold) begin
               r_latch_ones <= r_ones;
               r_latch_tens <= r_tens;
            end
         end
      end
   end

   assign w_disp_ones = r_hold ? r_latch_ones : r_ones;
   assign w_disp_tens = r_hold ? r_latch_tens : r_tens;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hex0 <= 7'b1000000;
         r_hex1 <= 7'b1000000;
      end else begin
         r_hex0 <= seg7(w_disp_ones);
         r_hex1 <= seg7(w_disp_tens);
      end
   end

   assign cur_sec = ({3'd0, r_tens} * 7'd10) + {3'd0, r_ones};
   assign full    = (r_state == S_DONE);
   assign hex0    = r_hex0;
   assign hex1    = r_hex1;
   assign state   = r_state;

endmodule
